// File: rtl/glitch_pulse_gen_if.sv
// Command/status bundle between the UART command decoder side and the
// glitch timing core. The slave modport is the timing core's view.
interface glitch_pulse_gen_if #(
   parameter int DELAY_W = 16,
   parameter int WIDTH_W = 8
);
   logic               trigger_in;
   logic               arm;
   logic               abort;
   logic [DELAY_W-1:0] delay;
   logic [WIDTH_W-1:0] width;
   logic               pulse_out;
   logic               armed;
   logic               busy;
   logic               done;

   modport master (
      output trigger_in, arm, abort, delay, width,
      input  pulse_out, armed, busy, done
   );

   modport slave (
      input  trigger_in, arm, abort, delay, width,
      output pulse_out, armed, busy, done
   );
endinterface

// File: rtl/glitch_pulse_gen.sv
// Glitch timing core: arm, wait for a qualified trigger edge, count a
// programmable delay, then drive the glitch pulse for a programmable width.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for an arm strobe; trigger edges are ignored
//   S_ARMED | delay/width latched, waiting for a trigger edge
//   S_DELAY | down-counting the trigger-to-pulse delay
//   S_PULSE | pulse_out high, down-counting the pulse width
//
// Both counts are loaded with the full programmed value and leave their state
// on the edge where the counter shows 1, so D and W cycles are counted exactly
// (a zero delay skips S_DELAY, a zero width skips the pulse entirely).
module glitch_pulse_gen #(
   parameter int DELAY_W      = 16,
   parameter int WIDTH_W      = 8,
   parameter int TRIG_FALLING = 0
) (
   input logic                clk,
   input logic                rst_n,
   glitch_pulse_gen_if.slave  bus
);

   localparam int   CNT_W     = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
   localparam logic TRIG_IDLE = (TRIG_FALLING != 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DELAY = 2'd2,
      S_PULSE = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_s1;
   logic               r_s2;
   logic               r_s3;
   logic [DELAY_W-1:0] r_dly;
   logic [WIDTH_W-1:0] r_wid;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pulse;
   logic               r_armed;
   logic               r_busy;
   logic               r_done;

   logic               w_edge;
   logic [CNT_W-1:0]   w_dly_ext;
   logic [CNT_W-1:0]   w_wid_ext;
   logic               w_cnt_last;

   // Synchronizer plus history flop run every cycle so a level that is already
   // present when arming has long since stopped looking like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= TRIG_IDLE;
         r_s2 <= TRIG_IDLE;
         r_s3 <= TRIG_IDLE;
      end else begin
         r_s1 <= bus.trigger_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge     = (TRIG_FALLING != 0) ? (~r_s2 & r_s3) : (r_s2 & ~r_s3);
   assign w_dly_ext  = CNT_W'(r_dly);
   assign w_wid_ext  = CNT_W'(r_wid);
   assign w_cnt_last = (r_cnt == CNT_W'(1));

   // Sequencer with registered outputs; abort overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dly   <= '0;
         r_wid   <= '0;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
         r_armed <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_armed <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.arm) begin
                     r_dly   <= bus.delay;
                     r_wid   <= bus.width;
                     r_armed <= 1'b1;
                     r_state <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  if (w_edge) begin
                     r_armed <= 1'b0;
                     if (r_wid == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                     end else if (r_dly == '0) begin
                        r_cnt   <= w_wid_ext;
                        r_busy  <= 1'b1;
                        r_pulse <= 1'b1;
                        r_state <= S_PULSE;
                     end else begin
                        r_cnt   <= w_dly_ext;
                        r_busy  <= 1'b1;
                        r_state <= S_DELAY;
                     end
                  end
               end
               S_DELAY: begin
                  if (w_cnt_last) begin
                     r_cnt   <= w_wid_ext;
                     r_pulse <= 1'b1;
                     r_state <= S_PULSE;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               S_PULSE: begin
                  if (w_cnt_last) begin
                     r_cnt   <= '0;
                     r_pulse <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.pulse_out = r_pulse;
   assign bus.armed     = r_armed;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: rising-edge, falling-edge and narrow-counter
// instances, randomized sequences checked against window arithmetic.
module tb_glitch_pulse_gen;

   localparam int BIG = 1 << 28;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        t_act = 1'b0;
   logic        arm_v = 1'b0;
   logic        abort_v = 1'b0;
   logic [15:0] dly_v = '0;
   logic [7:0]  wid_v = '0;
   int          sel = 0;
   logic [3:0]  obs;

   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    ma = BIG;
   int    mk = BIG;
   int    mb = BIG;
   int    m_d = 0;
   int    m_w = 0;
   string nm = "reset";

   always #5 clk = ~clk;

   glitch_pulse_gen_if #(.DELAY_W(16), .WIDTH_W(8)) bus_r ();
   glitch_pulse_gen_if #(.DELAY_W(16), .WIDTH_W(8)) bus_f ();
   glitch_pulse_gen_if #(.DELAY_W(4),  .WIDTH_W(3)) bus_s ();

   assign bus_r.trigger_in = t_act;
   assign bus_f.trigger_in = ~t_act;
   assign bus_s.trigger_in = t_act;
   assign bus_r.arm        = arm_v && (sel == 0);
   assign bus_f.arm        = arm_v && (sel == 1);
   assign bus_s.arm        = arm_v && (sel == 2);
   assign bus_r.abort      = abort_v && (sel == 0);
   assign bus_f.abort      = abort_v && (sel == 1);
   assign bus_s.abort      = abort_v && (sel == 2);
   assign bus_r.delay      = dly_v;
   assign bus_f.delay      = dly_v;
   assign bus_s.delay      = dly_v[3:0];
   assign bus_r.width      = wid_v;
   assign bus_f.width      = wid_v;
   assign bus_s.width      = wid_v[2:0];

   glitch_pulse_gen #(.DELAY_W(16), .WIDTH_W(8), .TRIG_FALLING(0)) u_dut_r (
      .clk(clk), .rst_n(rst_n), .bus(bus_r));
   glitch_pulse_gen #(.DELAY_W(16), .WIDTH_W(8), .TRIG_FALLING(1)) u_dut_f (
      .clk(clk), .rst_n(rst_n), .bus(bus_f));
   glitch_pulse_gen #(.DELAY_W(4), .WIDTH_W(3), .TRIG_FALLING(0)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s));

   always_comb begin
      obs = 4'b0000;
      case (sel)
         0: obs = {bus_r.pulse_out, bus_r.armed, bus_r.busy, bus_r.done};
         1: obs = {bus_f.pulse_out, bus_f.armed, bus_f.busy, bus_f.done};
         default: obs = {bus_s.pulse_out, bus_s.armed, bus_s.busy, bus_s.done};
      endcase
   end

   // Expected {pulse, armed, busy, done} after edge e. Arm captured at edge
   // ma, s1 first sees the active level at edge mk, abort applied at edge mb.
   function automatic logic [3:0] model(input int e);
      logic live, p, a, b, d;
      int   t0, t_end;
      live  = (e < mb);
      t0    = mk + 2;
      t_end = t0 + m_d + m_w;
      a = live && (e >= ma) && (e < t0);
      if (m_w == 0) begin
         p = 1'b0;
         b = 1'b0;
         d = live && (e == t0);
      end else begin
         p = live && (e >= t0 + m_d) && (e < t_end);
         b = live && (e >= t0) && (e < t_end);
         d = live && (e == t_end);
      end
      return {p, a, b, d};
   endfunction

   task automatic chk(input string tag, input logic o, input logic x);
      total++;
      assert (o === x) else begin
         bad++;
         $error("FAIL %s.%s cyc=%0d observed=%0b expected=%0b", nm, tag, cyc, o, x);
      end
   endtask

   task automatic tick();
      logic [3:0] m;
      @(posedge clk);
      cyc++;
      #1;
      m = model(cyc);
      chk("pulse_out", obs[3], m[3]);
      chk("armed",     obs[2], m[2]);
      chk("busy",      obs[1], m[1]);
      chk("done",      obs[0], m[0]);
   endtask

   // Inputs for the next edge: stray arm strobes only while ARMED (ignored),
   // delay/width noise always (only latched by an accepted arm).
   task automatic prep();
      int nxt;
      nxt     = cyc + 1;
      arm_v   = 1'b0;
      abort_v = (nxt == mb);
      dly_v   = 16'($urandom);
      wid_v   = 8'($urandom);
      if (nxt > ma && nxt <= mk + 2 && nxt <= mb)
         arm_v = ($urandom_range(0, 3) == 0);
   endtask

   task automatic run_seq(input int s, input int d, input int w, input bit pre,
                          input bit do_ab, input int ab_off, input string name);
      int stop;
      nm = name; sel = s; m_d = d; m_w = w;
      ma = BIG; mk = BIG; mb = BIG;
      arm_v = 1'b0; abort_v = 1'b0;
      t_act = pre;
      repeat (4) begin prep(); tick(); end
      dly_v = 16'(d); wid_v = 8'(w); arm_v = 1'b1; abort_v = 1'b0;
      ma = cyc + 1;
      tick();
      if (pre) begin
         repeat ($urandom_range(2, 6)) begin prep(); tick(); end
         t_act = 1'b0;
         repeat ($urandom_range(1, 4)) begin prep(); tick(); end
      end else begin
         repeat ($urandom_range(0, 5)) begin prep(); tick(); end
      end
      t_act = 1'b1;
      mk = cyc + 1;
      if (do_ab) mb = mk + 2 + ab_off;
      stop = mk + 2 + d + w + 3;
      while (cyc < stop) begin prep(); tick(); end
      t_act = 1'b0;
      repeat (2) begin prep(); tick(); end
      t_act = 1'b1;
      repeat (4) begin prep(); tick(); end
      t_act = 1'b0;
      repeat (4) begin prep(); tick(); end
   endtask

   initial begin
      int s, d, w, ab;
      bit pre, do_ab;
      #3;
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         chk("rst_pulse", obs[3], 1'b0);
         chk("rst_armed", obs[2], 1'b0);
         chk("rst_busy",  obs[1], 1'b0);
         chk("rst_done",  obs[0], 1'b0);
      end
      sel = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_seq(0, 5,   3,   1'b0, 1'b0, 0,  "d5w3");
      run_seq(0, 0,   1,   1'b0, 1'b0, 0,  "d0w1");
      run_seq(0, 4,   0,   1'b0, 1'b0, 0,  "d4w0");
      run_seq(0, 5,   3,   1'b1, 1'b0, 0,  "level_before_arm");
      run_seq(0, 100, 10,  1'b0, 1'b1, 50, "abort_mid_delay");
      run_seq(1, 2,   2,   1'b0, 1'b0, 0,  "falling_d2w2");
      run_seq(1, 2,   2,   1'b1, 1'b0, 0,  "falling_wrong_edge");
      run_seq(0, 3,   255, 1'b0, 1'b0, 0,  "max_width");
      run_seq(2, 15,  7,   1'b0, 1'b0, 0,  "small_max");
      run_seq(2, 0,   7,   1'b1, 1'b0, 0,  "small_d0");
      run_seq(2, 15,  1,   1'b0, 1'b1, -1, "small_abort_armed");

      for (int i = 0; i < 24; i++) begin
         s     = int'($urandom_range(0, 2));
         d     = (s == 2) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 20));
         w     = (s == 2) ? int'($urandom_range(0, 7))  : int'($urandom_range(0, 12));
         pre   = 1'($urandom_range(0, 1));
         do_ab = (w > 0) && ($urandom_range(0, 2) == 0);
         ab    = int'($urandom_range(0, d + w)) - 1;
         run_seq(s, d, w, pre, do_ab, ab, $sformatf("rand%0d", i));
      end

      // Reset asserted in the middle of a pulse must drop it at once.
      nm = "rst_mid"; sel = 0; m_d = 3; m_w = 20;
      ma = BIG; mk = BIG; mb = BIG;
      t_act = 1'b0; arm_v = 1'b0; abort_v = 1'b0;
      repeat (4) tick();
      dly_v = 16'd3; wid_v = 8'd20; arm_v = 1'b1;
      ma = cyc + 1;
      tick();
      arm_v = 1'b0;
      tick();
      t_act = 1'b1;
      mk = cyc + 1;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_pulse", obs[3], 1'b0);
      chk("async_busy",  obs[1], 1'b0);
      ma = BIG; mk = BIG; mb = BIG;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      t_act = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
